// File: rtl/buf_receiver.sv
`default_nettype none
// ============================================================================
// Module   : buf_receiver
// Brief    : Four-phase handshake receiver with FWFT output FIFO and stream checks.
// Revision : 1.0
// ============================================================================
module buf_receiver #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] LAST  = 32'd99
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     BtoR_REQ,
    input  logic [31:0]              DO,
    output logic                     RtoB_ACK,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [31:0]              rx_count,
    output logic                     seq_err,
    output logic                     done
);

    localparam int                  c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_DEPTH_L = (c_AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_capture;
    logic               w_pop;
    logic               w_full;

    logic               r_reqMeta;
    logic               r_reqSync;

    logic [31:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wrPtr;
    logic [c_AW-1:0]    r_rdPtr;
    logic [c_AW:0]      r_level;
    logic [31:0]        r_rxCount;
    logic [31:0]        r_expected;
    logic               r_seqErr;
    logic               r_done;

    // BtoR_REQ is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reqMeta <= 1'b0;
            r_reqSync <= 1'b0;
        end else begin
            r_reqMeta <= BtoR_REQ;
            r_reqSync <= r_reqMeta;
        end
    end

    // Full test uses pre-edge occupancy, so a same-cycle pop never frees a slot
    assign w_full = (r_level == c_DEPTH_L);
    assign w_pop  = (r_level != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_reqSync && !w_full) begin
                    w_capture   = 1'b1;
                    w_stateNext = ACK;
                end
            end
            ACK: begin
                if (!r_reqSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wrPtr] <= DO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_rxCount  <= '0;
            r_expected <= '0;
            r_seqErr   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wrPtr    <= r_wrPtr + c_AW'(1);
                r_rxCount  <= r_rxCount + 32'd1;
                r_expected <= DO + 32'd1;
                if (DO != r_expected) begin
                    r_seqErr <= 1'b1;
                end
                if (DO == LAST) begin
                    r_done <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_AW'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign RtoB_ACK   = (r_state == ACK);
    assign out_valid  = (r_level != '0);
    assign out_data   = r_mem[r_rdPtr];
    assign fifo_level = r_level;
    assign rx_count   = r_rxCount;
    assign seq_err    = r_seqErr;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/buf_receiver.md
BUF_RECEIVER -- requirements
Module: buf_receiver

Interface
- REQ-001: Parameter DEPTH, default 4, output FIFO entries; power of two, 2..16.
- REQ-002: Parameter LAST, default 99, data value that marks end of stream.
- REQ-003: clk  input  1  sole clock; all state updates on posedge clk.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: BtoR_REQ  input  1  four-phase request from BUF; asynchronous to clk.
- REQ-006: DO  input  32  data from BUF; stable whenever BtoR_REQ=1.
- REQ-007: RtoB_ACK  output  1  four-phase acknowledge to BUF; registered.
- REQ-008: out_valid  output  1  FIFO head valid.
- REQ-009: out_data  output  32  FIFO head data.
- REQ-010: out_ready  input  1  consumer accepts head when out_valid=1.
- REQ-011: fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- REQ-012: rx_count  output  32  words captured since reset; wraps 2^32-1 -> 0.
- REQ-013: seq_err  output  1  sticky; a captured word differed from the expected value.
- REQ-014: done  output  1  sticky; a word equal to LAST has been captured.

Function
- REQ-015: BtoR_REQ SHALL pass through a 2-flop synchroniser; req_s is the second flop output, 2-cycle latency.
- REQ-016: FSM states SHALL be IDLE and ACK only.
- REQ-017: IDLE: RtoB_ACK=0; if req_s=1 and fifo_level<DEPTH, capture DO that cycle and go to ACK.
- REQ-018: IDLE with req_s=1 and FIFO full SHALL hold in IDLE, no capture, until space exists.
- REQ-019: Full test SHALL use the pre-edge occupancy; a pop in the same cycle does not enable a capture that cycle.
- REQ-020: ACK: RtoB_ACK=1 from the cycle after capture; stay until req_s=0, then go to IDLE, RtoB_ACK=0 the following cycle.
- REQ-021: Exactly one capture per BtoR_REQ high phase; a new capture requires req_s to have been seen low in ACK.
- REQ-022: Capture SHALL push DO into the FIFO and increment rx_count by 1 (modulo 2^32).
- REQ-023: Sequence check: expected starts at 0; on capture, DO!=expected sets seq_err; expected <= DO+1 (32-bit wrap), i.e. resync to the received value.
- REQ-024: Capture with DO==LAST SHALL set done the next cycle; capture continues after done.
- REQ-025: FIFO first-word-fall-through: out_valid=1 iff level>0; out_data=oldest entry; pop when out_valid&&out_ready.
- REQ-026: Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and preserve order.
- REQ-027: Push into an empty FIFO SHALL assert out_valid the cycle after capture; pop when empty SHALL have no effect.
- REQ-028: Read/write pointers SHALL wrap modulo DEPTH.

Reset
- REQ-029: rst=1 at an edge SHALL set: RtoB_ACK=0, out_valid=0, fifo_level=0, rx_count=0, seq_err=0, done=0, expected=0, state IDLE, both sync flops 0.
- REQ-030: out_data is don't-care while out_valid=0.
- REQ-031: Reset mid-handshake (state ACK) SHALL drop RtoB_ACK the next cycle and discard FIFO contents; if BtoR_REQ is still high after rst falls, req_s rises 2 cycles later and a new capture occurs.
- REQ-032: Reset takes priority over capture, push and pop in the same cycle.

Verification
- REQ-033: Sender->BUF->buf_receiver, values 0..99, out_ready=1 -> 100 words out in order, rx_count=100, seq_err=0, done=1.
- REQ-034: Single handshake: BtoR_REQ rises at cycle t -> capture at t+2, RtoB_ACK=1 at t+3; BtoR_REQ falls at u -> RtoB_ACK=0 at u+3.
- REQ-035: out_ready=0, DEPTH=4, 6 requests -> 4 captured, 5th REQ unacknowledged, level=4; raise out_ready -> remaining 2 captured, order 0..5.
- REQ-036: Stream 0,1,3,4 -> seq_err set at capture of 3, stays set; no error flagged at 4.
- REQ-037: rst asserted in ACK with FIFO level 2 -> next cycle RtoB_ACK=0, level=0, rx_count=0, flags cleared; held REQ recaptured 2 cycles after rst release.
- REQ-038: Full FIFO with pop and REQ pending in same cycle -> no capture that cycle, capture next cycle, level returns to DEPTH.
